// File: rtl/cpu_dma_seq.sv
// ---------------------------------------------------------------------------
// cpu_dma_seq
// 68030-style DMA bus-master sequencer. It moves longwords between a FIFO and
// memory one bus cycle (or two, for a 16-bit port) at a time. It gives the bus
// back after BURST_LEN longwords, or earlier when the FIFO cannot continue.
//
// Parameters
//   BURST_LEN  longwords per bus tenure before the bus is released (1..255)
//   CNT_W      transfer counter width in longwords
//   TMO        clocks allowed in WAIT before a timeout (1..255)
//
// Ports
//   CLK, RST_                         clock, asynchronous active-low reset
//   DMAENA, DMADIR                    enable; 1 = FIFO->memory, 0 = memory->FIFO
//   LOAD_CNT, XFER_CNT                load the transfer length (IDLE/ERROR only)
//   FIFOEMPTY, FIFOFULL, FLUSHFIFO    FIFO status and flush request
//   BGRANT_, DSACK0_, DSACK1_, BERR_  bus grant, port-size acks, bus error
//   BR_, BGACK_, AS_, DS_             bus request, grant ack, strobes
//   RW, SIZ, A1                       cycle direction, size, word select
//   FIFO_RD, FIFO_WR, A_INC           one-clock pop/push/address-advance pulses
//   CNT, BUSY, DONE, ERR              remaining count and status
// ---------------------------------------------------------------------------
module cpu_dma_seq #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 24,
    parameter int TMO       = 255
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic             DMAENA,
    input  logic             DMADIR,
    input  logic             LOAD_CNT,
    input  logic [CNT_W-1:0] XFER_CNT,
    input  logic             FIFOEMPTY,
    input  logic             FIFOFULL,
    input  logic             FLUSHFIFO,
    input  logic             BGRANT_,
    input  logic             DSACK0_,
    input  logic             DSACK1_,
    input  logic             BERR_,
    output logic             BR_,
    output logic             BGACK_,
    output logic             AS_,
    output logic             DS_,
    output logic             RW,
    output logic [1:0]       SIZ,
    output logic             A1,
    output logic             FIFO_RD,
    output logic             FIFO_WR,
    output logic             A_INC,
    output logic [CNT_W-1:0] CNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_ADDR,
        ST_WAIT,
        ST_TERM,
        ST_NEXT,
        ST_RELEASE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
    localparam logic [7:0] TMO_MAX   = 8'(TMO);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       burst_q;
    logic [7:0]       timer_q;
    logic             a1_q;
    logic             half_q;      // first half of a 16-bit longword acknowledged
    logic             done_q;
    logic             err_q;
    logic             fifo_rd_q;
    logic             fifo_wr_q;
    logic             a_inc_q;

    logic             ready;
    logic             load_ok;
    logic             lw_done;     // longword finished on this WAIT->TERM edge
    logic             first_half;  // 16-bit port acked the low word
    logic             set_done;
    logic             to_error;

    assign ready    = DMAENA && (cnt_q != '0) && (DMADIR ? !FIFOEMPTY : !FIFOFULL);
    assign load_ok  = LOAD_CNT && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    assign to_error = (state_d == ST_ERROR) && (state_q != ST_ERROR);

    // Next-state decode
    always_comb begin
        state_d    = state_q;
        lw_done    = 1'b0;
        first_half = 1'b0;
        set_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready && !done_q) state_d = ST_REQ;
            end
            ST_REQ: begin
                // Nothing has started yet, so a dropped enable simply withdraws the request.
                if (!DMAENA)       state_d = ST_IDLE;
                else if (!BGRANT_) state_d = ST_GRANT;
            end
            ST_GRANT: state_d = ST_ADDR;
            ST_ADDR:  state_d = ST_WAIT;
            ST_WAIT: begin
                // Bus error wins over any acknowledge presented in the same clock.
                if (!BERR_) begin
                    state_d = ST_ERROR;
                end else if (!DSACK1_) begin
                    state_d = ST_TERM;
                    if (DSACK0_ && !a1_q) first_half = 1'b1;
                    else                  lw_done    = 1'b1;
                end else if (!DSACK0_) begin
                    state_d = ST_ERROR;   // 8-bit port is not supported
                end else if (timer_q == TMO_MAX) begin
                    state_d = ST_ERROR;
                end
            end
            ST_TERM: begin
                if (DSACK0_ && DSACK1_) state_d = half_q ? ST_ADDR : ST_NEXT;
            end
            ST_NEXT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RELEASE;
                    set_done = 1'b1;
                end else if (DMADIR && FIFOEMPTY && FLUSHFIFO) begin
                    state_d  = ST_RELEASE;
                    set_done = 1'b1;
                end else if ((burst_q == BURST_MAX) || !ready) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_ERROR: begin
                if (!DMAENA) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the current state
    always_comb begin
        BR_    = 1'b1;
        BGACK_ = 1'b1;
        AS_    = 1'b1;
        DS_    = 1'b1;
        RW     = 1'b1;
        BUSY   = 1'b1;
        case (state_q)
            ST_IDLE:  BUSY = 1'b0;
            ST_REQ:   BR_  = 1'b0;
            ST_GRANT: BGACK_ = 1'b0;
            ST_ADDR: begin
                BGACK_ = 1'b0;
                AS_    = 1'b0;
                RW     = ~DMADIR;
            end
            ST_WAIT: begin
                BGACK_ = 1'b0;
                AS_    = 1'b0;
                DS_    = 1'b0;
                RW     = ~DMADIR;
            end
            ST_TERM: begin
                BGACK_ = 1'b0;
                RW     = ~DMADIR;
            end
            ST_NEXT:    BGACK_ = 1'b0;
            ST_RELEASE: BUSY = 1'b1;
            ST_ERROR:   BUSY = 1'b0;
            default:    BUSY = 1'b0;
        endcase
    end

    assign SIZ     = a1_q ? 2'b10 : 2'b00;
    assign A1      = a1_q;
    assign FIFO_RD = fifo_rd_q;
    assign FIFO_WR = fifo_wr_q;
    assign A_INC   = a_inc_q;
    assign CNT     = cnt_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            burst_q   <= '0;
            timer_q   <= '0;
            a1_q      <= 1'b0;
            half_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fifo_rd_q <= 1'b0;
            fifo_wr_q <= 1'b0;
            a_inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            // Strobes fire during the first TERM clock only, so a TERM held
            // by slow ack negation still yields exactly one pulse.
            fifo_rd_q <= lw_done &  DMADIR;
            fifo_wr_q <= lw_done & ~DMADIR;
            a_inc_q   <= lw_done;

            if (load_ok)                       cnt_q <= XFER_CNT;
            else if (lw_done && cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);

            if ((state_q == ST_RELEASE) || to_error) burst_q <= '0;
            else if (lw_done)                        burst_q <= burst_q + 8'd1;

            if (state_q == ST_ADDR)                             timer_q <= '0;
            else if (state_q == ST_WAIT && timer_q != TMO_MAX)  timer_q <= timer_q + 8'd1;

            if (to_error) begin
                a1_q   <= 1'b0;
                half_q <= 1'b0;
            end else if (first_half) begin
                half_q <= 1'b1;
            end else if (state_q == ST_TERM && state_d == ST_ADDR) begin
                a1_q   <= 1'b1;
                half_q <= 1'b0;
            end else if (state_q == ST_TERM && state_d == ST_NEXT) begin
                a1_q   <= 1'b0;
            end

            if (set_done)                 done_q <= 1'b1;
            else if (!DMAENA || load_ok)  done_q <= 1'b0;

            if (to_error)     err_q <= 1'b1;
            else if (load_ok) err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_dma_seq.sv
module tb_cpu_dma_seq;
    localparam int BL = 4;
    localparam int CW = 24;
    localparam int TM = 20;

    logic          CLK       = 1'b0;
    logic          RST_      = 1'b1;
    logic          DMAENA    = 1'b0;
    logic          DMADIR    = 1'b0;
    logic          LOAD_CNT  = 1'b0;
    logic [CW-1:0] XFER_CNT  = '0;
    logic          FIFOEMPTY = 1'b1;
    logic          FIFOFULL  = 1'b0;
    logic          FLUSHFIFO = 1'b0;
    logic          BGRANT_   = 1'b1;
    logic          DSACK0_   = 1'b1;
    logic          DSACK1_   = 1'b1;
    logic          BERR_     = 1'b1;
    logic          BR_, BGACK_, AS_, DS_, RW;
    logic [1:0]    SIZ;
    logic          A1, FIFO_RD, FIFO_WR, A_INC;
    logic [CW-1:0] CNT;
    logic          BUSY, DONE, ERR;

    int checks   = 0;
    int failures = 0;

    // Environment knobs: slave port behaviour, grant delay, FIFO occupancy
    int slave_mode = 0;   // 0 = 32-bit, 1 = 16-bit, 2 = no ack, 3 = BERR, 4 = 8-bit
    int gdly       = 0;
    int fifo_level = 0;
    int fifo_space = 1000;

    typedef struct packed {
        logic          dir;
        logic [CW-1:0] cnt;
    } strobe_t;

    strobe_t    sq[$];   // expected FIFO strobes with CNT after the decrement
    logic [3:0] bq[$];   // expected {A1, SIZ, RW} for each address phase
    int         tq[$];   // expected longwords per bus tenure

    cpu_dma_seq #(.BURST_LEN(BL), .CNT_W(CW), .TMO(TM)) dut (
        .CLK(CLK), .RST_(RST_), .DMAENA(DMAENA), .DMADIR(DMADIR),
        .LOAD_CNT(LOAD_CNT), .XFER_CNT(XFER_CNT),
        .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL), .FLUSHFIFO(FLUSHFIFO),
        .BGRANT_(BGRANT_), .DSACK0_(DSACK0_), .DSACK1_(DSACK1_), .BERR_(BERR_),
        .BR_(BR_), .BGACK_(BGACK_), .AS_(AS_), .DS_(DS_), .RW(RW), .SIZ(SIZ), .A1(A1),
        .FIFO_RD(FIFO_RD), .FIFO_WR(FIFO_WR), .A_INC(A_INC), .CNT(CNT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what a transfer should look like on the bus and FIFO.
    task automatic push_model(input int n, input bit dir, input int mode, input int avail,
                              input bit flush, output int moved);
        strobe_t s;
        moved = 0;
        if (mode >= 2) begin
            bq.push_back({1'b0, 2'b00, ~dir});
            tq.push_back(0);
            return;
        end
        moved = (dir && flush && avail < n) ? avail : n;
        for (int i = 1; i <= moved; i++) begin
            s.dir = dir;
            s.cnt = CW'(n - i);
            sq.push_back(s);
            bq.push_back({1'b0, 2'b00, ~dir});
            if (mode == 1) bq.push_back({1'b1, 2'b10, ~dir});
        end
        for (int left = moved; left > 0; left -= BL)
            tq.push_back(left > BL ? BL : left);
    endtask

    // Bus arbiter, memory slave and FIFO occupancy, all driven on the falling edge
    initial begin : env
        int gcnt, wcnt, lat;
        gcnt = 0; wcnt = 0; lat = 0;
        forever begin
            @(negedge CLK);
            if (!BR_) begin
                if (gcnt >= gdly) BGRANT_ = 1'b0;
                else gcnt++;
            end else begin
                BGRANT_ = 1'b1;
                gcnt = 0;
            end
            if (AS_) begin
                DSACK0_ = 1'b1; DSACK1_ = 1'b1; BERR_ = 1'b1;
                wcnt = 0;
                lat = int'($urandom_range(0, 2));
            end else if (!DS_) begin
                if (wcnt < lat) wcnt++;
                else begin
                    case (slave_mode)
                        0: begin DSACK0_ = 1'b0; DSACK1_ = 1'b0; end
                        1: DSACK1_ = 1'b0;
                        3: BERR_ = 1'b0;
                        4: DSACK0_ = 1'b0;
                        default: ;
                    endcase
                end
            end
            if (FIFO_RD && fifo_level > 0) fifo_level--;
            if (FIFO_WR && fifo_space > 0) fifo_space--;
            FIFOEMPTY = (fifo_level == 0);
            FIFOFULL  = (fifo_space == 0);
        end
    end

    // Monitor: pops expectations whenever the DUT shows a strobe, address phase or tenure end
    initial begin : monitor
        logic       prev_as, prev_bg;
        int         tcount;
        strobe_t    es;
        logic [3:0] eb;
        int         et;
        prev_as = 1'b1; prev_bg = 1'b1; tcount = 0;
        forever begin
            @(negedge CLK);
            if (!BGACK_ && prev_bg) tcount = 0;
            if (FIFO_RD || FIFO_WR || A_INC) begin
                tcount++;
                if (sq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL strobe_unexpected: got rd=%0b wr=%0b inc=%0b, expected none", FIFO_RD, FIFO_WR, A_INC);
                end else begin
                    es = sq.pop_front();
                    chk("strobe_rd_wr_inc_cnt", {FIFO_RD, FIFO_WR, A_INC, CNT}, {es.dir, ~es.dir, 1'b1, es.cnt});
                end
            end
            if (!AS_ && prev_as) begin
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL addr_unexpected: got A1=%0b SIZ=%0b RW=%0b, expected none", A1, SIZ, RW);
                end else begin
                    eb = bq.pop_front();
                    chk("addr_a1_siz_rw", {A1, SIZ, RW}, eb);
                end
            end
            if (BGACK_ && !prev_bg) begin
                if (tq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tenure_unexpected: got %0d longwords, expected none", tcount);
                end else begin
                    et = tq.pop_front();
                    chk("tenure_len", tcount, et);
                end
            end
            prev_as = AS_;
            prev_bg = BGACK_;
        end
    end

    task automatic run_xfer(input int n, input bit dir, input int mode, input int avail,
                            input bit flush, input int gd, input bit poke);
        int moved, cyc;
        bit is_err, poked;
        is_err = (mode >= 2);
        poked  = 1'b0;
        @(negedge CLK);
        DMAENA = 1'b0; DMADIR = dir; FLUSHFIFO = flush;
        slave_mode = mode; gdly = gd;
        fifo_level = dir ? avail : 0;
        fifo_space = dir ? 0 : 1000;
        XFER_CNT = CW'(n); LOAD_CNT = 1'b1;
        @(negedge CLK);
        LOAD_CNT = 1'b0;
        push_model(n, dir, mode, avail, flush, moved);
        @(negedge CLK);
        DMAENA = 1'b1;
        cyc = 0;
        while (!DONE && !ERR && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            // A load while the bus is owned must be ignored.
            if (poke && !poked && !BGACK_) begin
                XFER_CNT = CW'(99); LOAD_CNT = 1'b1; poked = 1'b1;
            end else begin
                LOAD_CNT = 1'b0;
            end
        end
        LOAD_CNT = 1'b0;
        chk("xfer_finished_in_time", (cyc < 3000), 1'b1);
        repeat (3) @(negedge CLK);
        if (is_err) begin
            chk("err_err_done", {ERR, DONE}, 2'b10);
            chk("err_cnt_unchanged", CNT, n);
            chk("err_outputs_negated", {BR_, BGACK_, AS_, DS_, BUSY, FIFO_RD, FIFO_WR, A_INC}, 8'b1111_0000);
        end else begin
            chk("done_done_err", {DONE, ERR}, 2'b10);
            chk("final_cnt", CNT, n - moved);
            chk("idle_after_release", {BGACK_, BR_, BUSY, RW}, 4'b1101);
        end
        chk("scoreboard_drained", sq.size() + bq.size() + tq.size(), 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  cyc;
        bit  saw_br;
        // Reset state
        #3 RST_ = 1'b0;
        #2;
        chk("reset_outputs", {BR_, BGACK_, AS_, DS_, RW, SIZ, A1, FIFO_RD, FIFO_WR, A_INC, BUSY, DONE, ERR},
            14'b11111_00_0_000_000);
        chk("reset_cnt", CNT, 0);
        repeat (2) @(negedge CLK);
        RST_ = 1'b1;

        // Two longwords to memory, 32-bit port, grant after 3 clocks
        run_xfer(2, 1'b1, 0, 1000, 1'b0, 3, 1'b0);
        // One longword through a 16-bit port
        run_xfer(1, 1'b1, 1, 1000, 1'b0, 1, 1'b0);
        // Ten longwords from memory, split into 4,4,2 tenures; stray load ignored
        run_xfer(10, 1'b0, 0, 0, 1'b0, 2, 1'b1);

        // FIFO empties after 3 pops with flush requested
        run_xfer(8, 1'b1, 0, 3, 1'b1, 2, 1'b0);
        @(negedge CLK);
        fifo_level = 100;
        saw_br = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (!BR_) saw_br = 1'b1;
        end
        chk("done_sticky_no_rerequest", {saw_br, DONE}, 2'b01);

        // Timeout, then leaving ERROR once enable drops
        run_xfer(5, 1'b1, 2, 1000, 1'b0, 0, 1'b0);
        @(negedge CLK);
        DMAENA = 1'b0; gdly = 50;
        @(negedge CLK);
        DMAENA = 1'b1; slave_mode = 0;
        cyc = 0;
        while (BR_ && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        chk("error_exit_rerequests", {BR_, BUSY, ERR}, 3'b011);
        DMAENA = 1'b0;
        repeat (2) @(negedge CLK);
        chk("req_withdrawn", {BR_, BUSY, BGACK_}, 3'b101);

        // Bus error and 8-bit port both end in ERROR
        run_xfer(4, 1'b0, 3, 0, 1'b0, 1, 1'b0);
        run_xfer(3, 1'b1, 4, 1000, 1'b0, 0, 1'b0);

        // Reset in the middle of a WAIT
        @(negedge CLK);
        DMAENA = 1'b0; DMADIR = 1'b1; FLUSHFIFO = 1'b0; slave_mode = 2; gdly = 0;
        fifo_level = 1000; XFER_CNT = CW'(3); LOAD_CNT = 1'b1;
        @(negedge CLK);
        LOAD_CNT = 1'b0;
        bq.push_back({1'b0, 2'b00, 1'b0});
        tq.push_back(0);
        @(negedge CLK);
        DMAENA = 1'b1;
        cyc = 0;
        while (DS_ && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        chk("reached_wait", DS_, 1'b0);
        #2 RST_ = 1'b0;
        #1;
        chk("reset_in_wait_outputs", {BR_, BGACK_, AS_, DS_, RW, SIZ, A1, FIFO_RD, FIFO_WR, A_INC, BUSY, DONE, ERR},
            14'b11111_00_0_000_000);
        chk("reset_in_wait_cnt", CNT, 0);
        repeat (2) @(negedge CLK);
        chk("reset_held_no_strobes", {FIFO_RD, FIFO_WR, A_INC, AS_, DS_}, 5'b00011);
        RST_ = 1'b1;
        DMAENA = 1'b0;
        @(negedge CLK);
        chk("reset_scoreboard_drained", sq.size() + bq.size() + tq.size(), 0);

        // Randomised transfers
        for (int i = 0; i < 10; i++) begin
            int  n, mode, avail, gd;
            bit  dir, flush;
            n     = int'($urandom_range(1, 12));
            dir   = 1'($urandom_range(0, 1));
            mode  = int'($urandom_range(0, 1));
            flush = dir && ($urandom_range(0, 1) == 1);
            avail = flush ? int'($urandom_range(1, 12)) : 1000;
            gd    = int'($urandom_range(0, 4));
            run_xfer(n, dir, mode, avail, flush, gd, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_dma_seq.md
CPU_DMA_SEQ -- requirements
Module: cpu_dma_seq

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: longwords moved per bus tenure before the bus is released (1..255).
REQ-002 SHALL have parameter CNT_W, default 24: transfer-counter width in longwords.
REQ-003 SHALL have parameter TMO, default 255: clocks allowed in WAIT before timeout (1..255).
REQ-004 CLK  in  1  sole clock; all state on rising edge.
REQ-005 RST_  in  1  asynchronous, active-low reset.
REQ-006 DMAENA, DMADIR  in  1 each  enable; direction (1 = FIFO->memory write, 0 = memory->FIFO read).
REQ-007 LOAD_CNT  in  1, XFER_CNT  in  CNT_W  load transfer length (longwords).
REQ-008 FIFOEMPTY, FIFOFULL, FLUSHFIFO  in  1 each  FIFO status; flush request.
REQ-009 BGRANT_, DSACK0_, DSACK1_, BERR_  in  1 each  68030 bus grant, port-size acknowledges, bus error.
REQ-010 BR_, BGACK_, AS_, DS_  out  1 each  bus request, grant acknowledge, address strobe, data strobe.
REQ-011 RW  out  1 (0 = write), SIZ  out  2, A1  out  1  cycle direction, size, word select.
REQ-012 FIFO_RD, FIFO_WR  out  1 each  one-clock pop/push strobes.
REQ-013 A_INC  out  1, CNT  out  CNT_W, BUSY, DONE, ERR  out  1 each  address-advance pulse, remaining count, status.

Function
REQ-014 States SHALL be IDLE, REQ, GRANT, ADDR, WAIT, TERM, NEXT, RELEASE, ERROR.
REQ-015 "Ready" SHALL mean DMAENA & CNT!=0 & (DMADIR ? !FIFOEMPTY : !FIFOFULL).
REQ-016 IDLE->REQ on Ready; BR_ low from REQ entry until GRANT.
REQ-017 REQ->GRANT when BGRANT_=0; GRANT drives BGACK_ low, BR_ high; GRANT->ADDR after 1 clock.
REQ-018 ADDR (1 clock): AS_ low, RW=~DMADIR, SIZ=00 with A1=0 for a new longword, SIZ=10 with A1=1 for second half.
REQ-019 WAIT: DS_ low; timer counts clocks; exit on first clock with DSACK1_=0 or BERR_=0 or timer=TMO.
REQ-020 DSACK1_=0 & DSACK0_=0 -> 32-bit port; longword complete.
REQ-021 DSACK1_=0 & DSACK0_=1 with A1=0 -> 16-bit port; after TERM return to ADDR with A1=1; longword complete after the second ack.
REQ-022 DSACK0_=0 & DSACK1_=1 (8-bit port), BERR_=0, or timeout -> ERROR; BERR_ takes priority over simultaneous DSACK.
REQ-023 TERM: AS_/DS_ high; held until DSACK0_ and DSACK1_ both high; on longword complete exactly one FIFO_RD (write) or FIFO_WR (read) pulse, one A_INC pulse, CNT-1, burst counter+1.
REQ-024 NEXT: CNT=0 -> RELEASE, DONE; DMADIR=1 & FIFOEMPTY & FLUSHFIFO -> RELEASE, DONE; burst=BURST_LEN or not Ready -> RELEASE; else ADDR.
REQ-025 RELEASE: BGACK_ high, burst counter cleared, RW high; ->IDLE next clock.
REQ-026 DONE SHALL be sticky from RELEASE until LOAD_CNT or DMAENA=0; IDLE shall not re-request while DONE.
REQ-027 ERROR: all bus outputs negated, BGACK_ high, ERR sticky; exit to IDLE only when DMAENA=0.
REQ-028 DMAENA falling mid-cycle SHALL not abort a started longword; release occurs at NEXT.
REQ-029 LOAD_CNT SHALL be honoured only in IDLE/ERROR; ignored otherwise; CNT never wraps below 0.
REQ-030 BUSY SHALL be high in every state except IDLE and ERROR.

Reset
REQ-031 RST_ low SHALL immediately force IDLE, BR_/BGACK_/AS_/DS_/RW=1, SIZ=00, A1=0, FIFO_RD/FIFO_WR/A_INC=0, CNT=0, BUSY/DONE/ERR=0, timer and burst counter 0, including mid-cycle.

Verification
REQ-032 XFER_CNT=2, DMADIR=1, FIFO non-empty, grant after 3 clocks, 32-bit acks -> two ADDR/WAIT/TERM cycles, 2 FIFO_RD, CNT=0, DONE=1, BGACK_ high.
REQ-033 16-bit port (DSACK1_ only), CNT=1 -> two bus cycles A1=0/SIZ=00 then A1=1/SIZ=10, single FIFO_RD.
REQ-034 CNT=10, BURST_LEN=4, FIFO always ready -> three tenures of 4,4,2 longwords with BR_ re-asserted between.
REQ-035 No DSACK for TMO clocks -> ERROR, ERR=1, no FIFO strobe, CNT unchanged; DMAENA=0 returns IDLE.
REQ-036 DMADIR=1, CNT=8, FIFO empties after 3 pops with FLUSHFIFO=1 -> DONE=1, CNT=5.
REQ-037 RST_ low during WAIT -> all outputs at reset values on the same clock edge, no strobes.
